gshare_predictor: RTL and testbench

//  Parametrised gshare direction predictor for stage IF1. A speculative global history register (GHR)
//  is XOR-hashed with the fetch PC to index a table of saturating counters. The block returns a

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_sat_ctr.sv | 19 +
 rtl/gshare_predictor.sv | 103 ++++++++++
 tb/tb_gshare_predictor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // Weakly-taken counter value: only the MSB set.
  function automatic logic [31:0] weak_t(input int unsigned ctr_width);
    return 32'd1 << (ctr_width - 1);
  endfunction

  // gshare hash: word-aligned PC bits XOR zero-extended history. Callers keep the low IDX_WIDTH bits.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int unsigned pc_lsb);
    return (pc >> pc_lsb) ^ ghr;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter step used to train one table entry.
module bp_sat_ctr #(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] next
);

  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != '1) next = ctr + 1'b1;
    end else begin
      if (ctr != '0) next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: speculative GHR hashed with the fetch PC into a counter table,
// trained and repaired from EX, swept to weakly-taken by an init FSM after reset.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned IDX_WIDTH = 8,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned PC_LSB    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if1_valid,
  input  logic [31:0]          if1_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  output logic                 ready,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic [GHR_WIDTH-1:0] ex_ghr,
  input  logic                 ex_taken,
  input  logic                 ex_mispredict
);

  localparam int unsigned DEPTH = 1 << IDX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] WEAK_T = CTR_WIDTH'(weak_t(CTR_WIDTH));

  bp_state_t            state;
  bp_state_t            state_next;
  logic [IDX_WIDTH-1:0] init_ptr;
  logic [GHR_WIDTH-1:0] ghr_q;
  logic [CTR_WIDTH-1:0] pht [DEPTH];

  logic                 run;
  logic                 pht_we;
  logic [IDX_WIDTH-1:0] pht_waddr;
  logic [CTR_WIDTH-1:0] pht_wdata;
  logic [IDX_WIDTH-1:0] idx_if1;
  logic [IDX_WIDTH-1:0] idx_ex;
  logic [CTR_WIDTH-1:0] ctr_next;

  assign idx_if1 = IDX_WIDTH'(bp_index(if1_pc, 32'(ghr_q), PC_LSB));
  assign idx_ex  = IDX_WIDTH'(bp_index(ex_pc, 32'(ex_ghr), PC_LSB));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_ptr == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Single write port: the sweep owns it in INIT, EX training owns it in RUN.
  always_comb begin
    run       = (state == RUN);
    ready     = run;
    pht_we    = 1'b0;
    pht_waddr = init_ptr;
    pht_wdata = WEAK_T;
    if (!run) begin
      pht_we = rst_n;
    end else if (ex_valid) begin
      pht_we    = rst_n;
      pht_waddr = idx_ex;
      pht_wdata = ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              init_ptr <= '0;
    else if (state == INIT)  init_ptr <= init_ptr + 1'b1;
  end

  // if1_valid consumes the prediction shown this cycle; an EX mispredict repair wins over it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (run) begin
      if (ex_valid && ex_mispredict) ghr_q <= GHR_WIDTH'({ex_ghr, ex_taken});
      else if (if1_valid)            ghr_q <= GHR_WIDTH'({ghr_q, pred_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
  end

  bp_sat_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_sat_ctr (
    .ctr   (pht[idx_ex]),
    .taken (ex_taken),
    .next  (ctr_next)
  );

  assign pred_taken = run & pht[idx_if1][CTR_WIDTH-1];
  assign pred_ghr   = run ? ghr_q : '0;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: expected predictions are queued by the driver and
// consumed by a negedge monitor.
module tb_gshare_predictor;

  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if1_valid = 1'b0;
  logic [31:0]   if1_pc = '0;
  logic          pred_taken;
  logic [GW-1:0] pred_ghr;
  logic          ready;
  logic          ex_valid = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic [GW-1:0] ex_ghr = '0;
  logic          ex_taken = 1'b0;
  logic          ex_mispredict = 1'b0;

  logic          obs = 1'b0;
  logic [GW:0]   exp_q[$];
  logic [GW:0]   exp_item;
  int            checks = 0;
  int            errors = 0;
  string         cur_test = "none";

  gshare_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if1_valid     (if1_valid),
    .if1_pc        (if1_pc),
    .pred_taken    (pred_taken),
    .pred_ghr      (pred_ghr),
    .ready         (ready),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_ghr        (ex_ghr),
    .ex_taken      (ex_taken),
    .ex_mispredict (ex_mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: actual=%0h expected=%0h", cur_test, name, act, exp);
    end
  endtask

  // Monitor: compare the combinational prediction mid-cycle whenever the driver flagged one.
  always @(negedge clk) begin
    if (obs) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check("pred_taken", 32'(pred_taken), 32'(exp_item[GW]));
        check("pred_ghr", 32'(pred_ghr), 32'(exp_item[GW-1:0]));
      end
    end
  end

  task automatic set_ex(input logic [31:0] pc, input logic [GW-1:0] ghr,
                        input logic taken, input logic misp);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_ghr        = ghr;
    ex_taken      = taken;
    ex_mispredict = misp;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic o,
                      input logic et, input logic [GW-1:0] eg);
    if1_valid = v;
    if1_pc    = pc;
    obs       = o;
    if (o) exp_q.push_back({et, eg});
    @(posedge clk);
    #1;
    if1_valid     = 1'b0;
    obs           = 1'b0;
    ex_valid      = 1'b0;
    ex_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(ready), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int exp_cycles);
    int k;
    k = 0;
    while (!ready && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ready_latency", 32'(k), 32'(exp_cycles));
  endtask

  task automatic train_obs(input logic taken, input logic exp_t);
    set_ex(32'h100, 8'h00, taken, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h100, 1'b1, exp_t, 8'h00);
  endtask

  task automatic init_with_pulses();
    int k;
    k = 0;
    while (!ready && k < 400) begin
      if (k >= 200 && k < 206) set_ex(32'h100, 8'h55, 1'b0, 1'b1);
      if (k == 210) step(1'b1, 32'h100, 1'b1, 1'b0, 8'h00);
      else          step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      k++;
    end
    check("ready_latency_after_pulse", 32'(k), 32'd256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    cur_test = "t1_init";
    do_reset();
    wait_ready(256);
    for (int i = 0; i < 256; i++) step(1'b0, 32'(i) << 2, 1'b1, 1'b1, 8'h00);

    cur_test = "t2_train";
    set_ex(32'h100, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h100, 1'b1, 1'b1, 8'h00);
    step(1'b0, 32'h100, 1'b1, 1'b0, 8'h00);
    train_obs(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) train_obs(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) train_obs(1'b1, (i >= 1));
    train_obs(1'b0, 1'b1);

    cur_test = "t3_ghr_shift";
    step(1'b1, 32'h0, 1'b1, 1'b1, 8'h00);
    step(1'b1, 32'h0, 1'b1, 1'b1, 8'h01);
    step(1'b1, 32'h0, 1'b1, 1'b1, 8'h03);
    step(1'b0, 32'h0, 1'b1, 1'b1, 8'h07);

    cur_test = "t4_repair";
    set_ex(32'h0, 8'h55, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b1, 8'h07);
    step(1'b0, 32'h0, 1'b1, 1'b1, 8'hAA);
    step(1'b0, 32'h3FC, 1'b1, 1'b0, 8'hAA);

    cur_test = "t5_rbw";
    set_ex(32'h100, 8'h00, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    set_ex(32'h100, 8'h00, 1'b1, 1'b0);
    step(1'b0, 32'h3A8, 1'b1, 1'b0, 8'hAA);
    step(1'b0, 32'h3A8, 1'b1, 1'b1, 8'hAA);

    cur_test = "t6_midinit_reset";
    do_reset();
    check("ghr_after_reset", 32'(dut.ghr_q), 32'd0);
    for (int i = 0; i < 100; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("init_ptr_before_pulse", 32'(dut.init_ptr), 32'd100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("init_ptr_after_pulse", 32'(dut.init_ptr), 32'd0);
    check("ghr_after_pulse", 32'(dut.ghr_q), 32'd0);
    check("ready_after_pulse", 32'(ready), 32'd0);
    rst_n = 1'b1;
    init_with_pulses();
    step(1'b0, 32'h100, 1'b1, 1'b1, 8'h00);
    step(1'b0, 32'h154, 1'b1, 1'b1, 8'h00);
    step(1'b0, 32'h0, 1'b1, 1'b1, 8'h00);

    cur_test = "end";
    step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
